// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module : ifetch
// Desc   : In-order instruction fetch with a DEPTH-entry buffer and redirect flush
// Rev    : 1.0  initial release
// ============================================================================
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_vld,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_vld,
    input  logic [63:0] redirect_pc,
    input  logic        dec_rdy,
    output logic        ifetch_inst_vld,
    output logic [63:0] ifetch_inst,
    output logic [63:0] ifetch_inst_pc
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0]    C_RUN   = 1'b0;
    localparam logic [0:0]    C_DRAIN = 1'b1;
    localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

    logic [0:0]    r_state;
    logic          r_req_en;
    logic [63:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_kill_cnt;
    logic [CW-1:0] r_fifo_cnt;
    logic [PW-1:0] r_fifo_rd;
    logic [PW-1:0] r_fifo_wr;
    logic [PW-1:0] r_pq_rd;
    logic [PW-1:0] r_pq_wr;
    logic [31:0]   r_fifo_inst [DEPTH];
    logic [63:0]   r_fifo_pc   [DEPTH];
    logic [63:0]   r_pq_pc     [DEPTH];

    logic [0:0]    w_state_next;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_kill_next;
    logic [CW-1:0] w_fifo_cnt_next;
    logic [CW:0]   w_inflight;
    logic          w_req_fire;
    logic          w_rsp_take;
    logic          w_rsp_keep;
    logic          w_rsp_kill;
    logic          w_pop;
    logic          w_unused_ok;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered occupancy only; a pop this cycle frees no slot until next cycle
    assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
    assign imem_req_vld = r_req_en & (r_state == C_RUN) & (w_inflight < C_DEPTH) & ~redirect_vld;
    assign imem_req_addr = r_fetch_pc;

    assign w_req_fire = imem_req_vld & imem_req_rdy;
    assign w_rsp_take = imem_rsp_vld & (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_take & (r_kill_cnt == '0);
    assign w_rsp_kill = w_rsp_take & (r_kill_cnt != '0);

    assign ifetch_inst_vld = (r_fifo_cnt != '0);
    assign ifetch_inst     = {32'h0, r_fifo_inst[r_fifo_rd]};
    assign ifetch_inst_pc  = r_fifo_pc[r_fifo_rd];
    assign w_pop           = ifetch_inst_vld & dec_rdy & ~redirect_vld;

    assign w_unused_ok = ^redirect_pc[1:0];

    always_comb begin
        w_state_next    = r_state;
        w_out_next      = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
        w_kill_next     = r_kill_cnt;
        w_fifo_cnt_next = r_fifo_cnt + CW'(w_rsp_keep) - CW'(w_pop);
        if (redirect_vld) begin
            // Everything still in flight after this cycle must be thrown away
            w_kill_next     = w_out_next;
            w_fifo_cnt_next = '0;
        end else if (w_rsp_kill) begin
            w_kill_next = r_kill_cnt - CW'(1);
        end
        case (r_state)
            C_RUN:   if (redirect_vld && (w_kill_next != '0)) w_state_next = C_DRAIN;
            C_DRAIN: if (w_kill_next == '0) w_state_next = C_RUN;
            default: w_state_next = C_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= C_RUN;
            r_req_en      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_fifo_cnt    <= '0;
            r_fifo_rd     <= '0;
            r_fifo_wr     <= '0;
            r_pq_rd       <= '0;
            r_pq_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= RESET_PC;
                r_pq_pc[i]     <= RESET_PC;
            end
        end else begin
            r_state       <= w_state_next;
            r_req_en      <= 1'b1;
            r_outstanding <= w_out_next;
            r_kill_cnt    <= w_kill_next;
            r_fifo_cnt    <= w_fifo_cnt_next;

            if (redirect_vld) begin
                r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end

            if (w_req_fire) begin
                r_pq_pc[r_pq_wr] <= r_fetch_pc;
                r_pq_wr          <= f_next(r_pq_wr);
            end
            if (w_rsp_take) begin
                r_pq_rd <= f_next(r_pq_rd);
            end

            if (redirect_vld) begin
                r_fifo_rd <= '0;
                r_fifo_wr <= '0;
            end else begin
                if (w_rsp_keep) begin
                    r_fifo_inst[r_fifo_wr] <= imem_rsp_data;
                    r_fifo_pc[r_fifo_wr]   <= r_pq_pc[r_pq_rd];
                    r_fifo_wr              <= f_next(r_fifo_wr);
                end
                if (w_pop) begin
                    r_fifo_rd <= f_next(r_fifo_rd);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch
// Desc   : Directed scoreboard bench for ifetch with a one-cycle memory model
// Rev    : 1.0  initial release
// ============================================================================
module tb_ifetch;
    logic        clk;
    logic        rst_n;
    logic        imem_req_vld;
    logic [63:0] imem_req_addr;
    logic        imem_req_rdy;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_data;
    logic        redirect_vld;
    logic [63:0] redirect_pc;
    logic        dec_rdy;
    logic        ifetch_inst_vld;
    logic [63:0] ifetch_inst;
    logic [63:0] ifetch_inst_pc;

    logic        mem_stall;
    logic        stray;
    logic [63:0] mem_q   [$];
    logic [63:0] req_log [$];
    logic [63:0] exp_q   [$];
    int          checks;
    int          failures;

    ifetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_vld    (imem_req_vld),
        .imem_req_addr   (imem_req_addr),
        .imem_req_rdy    (imem_req_rdy),
        .imem_rsp_vld    (imem_rsp_vld),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_vld    (redirect_vld),
        .redirect_pc     (redirect_pc),
        .dec_rdy         (dec_rdy),
        .ifetch_inst_vld (ifetch_inst_vld),
        .ifetch_inst     (ifetch_inst),
        .ifetch_inst_pc  (ifetch_inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        int i;
        i = 0;
        while (req_log.size() < n && i < 60) begin
            step();
            i++;
        end
        chk("req_count", 64'(req_log.size()), 64'(n));
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            step();
            i++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: record accepted requests, answer one cycle later in order
    always @(negedge clk) begin
        if (rst_n && imem_req_vld && imem_req_rdy) begin
            mem_q.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
        end
    end

    initial begin
        logic [63:0] a;
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_rsp_vld  = 1'b0;
            imem_rsp_data = '0;
            if (!rst_n) begin
                mem_q.delete();
            end else if (stray) begin
                imem_rsp_vld  = 1'b1;
                imem_rsp_data = 32'hDEAD_BEEF;
            end else if (!mem_stall && mem_q.size() != 0) begin
                a = mem_q.pop_front();
                imem_rsp_vld  = 1'b1;
                imem_rsp_data = inst_of(a);
            end
        end
    end

    // Monitor: every instruction decode consumes is compared against the scoreboard
    always @(negedge clk) begin
        logic [63:0] pc;
        if (rst_n && ifetch_inst_vld && dec_rdy && !redirect_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst_pc", ifetch_inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                pc = exp_q.pop_front();
                chk("inst_pc", ifetch_inst_pc, pc);
                chk("inst_data", ifetch_inst, {32'h0, inst_of(pc)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; imem_req_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
        dec_rdy = 1'b0; mem_stall = 1'b0; stray = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_vld", imem_req_vld, 0);
        chk("rst_inst_vld", ifetch_inst_vld, 0);
        chk("rst_inst", ifetch_inst, 0);
        chk("rst_inst_pc", ifetch_inst_pc, 64'h8000_0000);

        // Streaming fetch after reset release
        step();
        rst_n = 1'b1; imem_req_rdy = 1'b1; dec_rdy = 1'b1;
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h8000_0004);
        exp_q.push_back(64'h8000_0008);
        @(negedge clk);
        chk("release_no_req", imem_req_vld, 0);
        wait_log(3);
        imem_req_rdy = 1'b0;
        wait_drain();
        chk("t1_addr0", req_log[0], 64'h8000_0000);
        chk("t1_addr1", req_log[1], 64'h8000_0004);
        chk("t1_addr2", req_log[2], 64'h8000_0008);
        req_log.delete();

        // Decode stalled: buffer fills to DEPTH and head holds
        dec_rdy = 1'b0; imem_req_rdy = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("t2_inst_vld", ifetch_inst_vld, 1);
        chk("t2_req_vld", imem_req_vld, 0);
        chk("t2_req_count", 64'(req_log.size()), 2);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("t2_head_hold", ifetch_inst_pc, 64'h8000_000C);
        end
        step();
        imem_req_rdy = 1'b0;
        exp_q.push_back(64'h8000_000C);
        exp_q.push_back(64'h8000_0010);
        dec_rdy = 1'b1;
        wait_drain();
        chk("t2_addr0", req_log[0], 64'h8000_000C);
        chk("t2_addr1", req_log[1], 64'h8000_0010);
        req_log.delete();

        // Redirect with two requests outstanding
        mem_stall = 1'b1; imem_req_rdy = 1'b1;
        wait_log(2);
        redirect_vld = 1'b1; redirect_pc = 64'h8000_1003;
        exp_q.push_back(64'h8000_1000);
        @(negedge clk);
        chk("t3_redir_no_req", imem_req_vld, 0);
        step();
        redirect_vld = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        chk("t3_fifo_empty", ifetch_inst_vld, 0);
        chk("t3_drain_no_req", imem_req_vld, 0);
        wait_log(3);
        imem_req_rdy = 1'b0;
        wait_drain();
        chk("t3_addr0", req_log[0], 64'h8000_0014);
        chk("t3_new_addr", req_log[2], 64'h8000_1000);
        req_log.delete();

        // Redirect colliding with a response and a decode pop
        dec_rdy = 1'b0; mem_stall = 1'b1; imem_req_rdy = 1'b1;
        wait_log(2);
        imem_req_rdy = 1'b0; mem_stall = 1'b0;
        step();
        mem_stall = 1'b1;
        @(negedge clk);
        chk("t4_head_vld", ifetch_inst_vld, 1);
        chk("t4_head_pc", ifetch_inst_pc, 64'h8000_1004);
        step();
        mem_stall = 1'b0; redirect_vld = 1'b1; redirect_pc = 64'h8000_2000;
        dec_rdy = 1'b1; imem_req_rdy = 1'b1;
        exp_q.push_back(64'h8000_2000);
        @(negedge clk);
        chk("t4_redir_no_req", imem_req_vld, 0);
        step();
        redirect_vld = 1'b0;
        @(negedge clk);
        chk("t4_inst_vld", ifetch_inst_vld, 0);
        chk("t4_req_vld", imem_req_vld, 1);
        chk("t4_req_addr", imem_req_addr, 64'h8000_2000);
        step();
        imem_req_rdy = 1'b0;
        wait_drain();
        chk("t4_req_total", 64'(req_log.size()), 3);
        req_log.delete();

        // Unaccepted request withdrawn by redirect
        repeat (5) step();
        @(negedge clk);
        chk("t5_pending_vld", imem_req_vld, 1);
        chk("t5_pending_addr", imem_req_addr, 64'h8000_2004);
        step();
        redirect_vld = 1'b1; redirect_pc = 64'h8000_3000;
        @(negedge clk);
        chk("t5_withdrawn", imem_req_vld, 0);
        step();
        redirect_vld = 1'b0; imem_req_rdy = 1'b1;
        exp_q.push_back(64'h8000_3000);
        @(negedge clk);
        chk("t5_new_vld", imem_req_vld, 1);
        chk("t5_new_addr", imem_req_addr, 64'h8000_3000);
        step();
        imem_req_rdy = 1'b0;
        wait_drain();
        chk("t5_req_total", 64'(req_log.size()), 1);
        if (req_log.size() != 0) chk("t5_req_addr", req_log[0], 64'h8000_3000);
        req_log.delete();

        // Reset mid-operation, then a stray response
        dec_rdy = 1'b0; mem_stall = 1'b1; imem_req_rdy = 1'b1;
        wait_log(2);
        imem_req_rdy = 1'b0; mem_stall = 1'b0;
        step();
        mem_stall = 1'b1;
        @(negedge clk);
        chk("t6_buffered", ifetch_inst_vld, 1);
        step();
        rst_n = 1'b0;
        req_log.delete();
        @(negedge clk);
        chk("t6_rst_req_vld", imem_req_vld, 0);
        chk("t6_rst_inst_vld", ifetch_inst_vld, 0);
        chk("t6_rst_inst", ifetch_inst, 0);
        chk("t6_rst_inst_pc", ifetch_inst_pc, 64'h8000_0000);
        step();
        step();
        rst_n = 1'b1; stray = 1'b1; imem_req_rdy = 1'b1; dec_rdy = 1'b1; mem_stall = 1'b0;
        exp_q.push_back(64'h8000_0000);
        @(negedge clk);
        chk("t6_release_no_req", imem_req_vld, 0);
        step();
        stray = 1'b0;
        @(negedge clk);
        chk("t6_stray_ignored", ifetch_inst_vld, 0);
        step();
        imem_req_rdy = 1'b0;
        wait_drain();
        chk("t6_req_total", 64'(req_log.size()), 1);
        if (req_log.size() != 0) chk("t6_restart_addr", req_log[0], 64'h8000_0000);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
